div_unit: RTL
=============

# div_unit

Multi-cycle 32-bit integer divider serving the EX stage for MIPS `div`/`divu`. EX raises a start request with operands and stalls the pipeline through its existing EX stall request until `ready_o` is asserted. EX then forwards `result_o` as {HI=remainder, LO=quotient} into the existing HI/LO write path (EX/MEM → MEM → MEM/WB → HI/LO register). The divider uses radix-2 restoring division, one quotient bit per cycle, with sign correction for signed operations.

## Interface
- DATA_W, 32, operand width; the counter and result widths derive from it.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- signed_div_i  in  1  1 = signed (`div`), 0 = unsigned (`divu`); sampled with start
- opdata1_i  in  DATA_W  dividend; sampled with start
- opdata2_i  in  DATA_W  divisor; sampled with start
- start_i  in  1  request; EX holds it high until it has consumed the result
- annul_i  in  1  cancel; aborts a request or an operation in progress
- result_o  out  2*DATA_W  {remainder, quotient}; meaningful only while ready_o=1
- ready_o  out  1  result valid

## Operation
- States: FREE, BYZERO, ON, END.
- FREE
  - start_i=1 and annul_i=0 with opdata2_i=0 → BYZERO.
  - start_i=1 and annul_i=0 otherwise → ON. Latch |a| and |b|: take the two's complement of an operand only when signed_div_i=1 and that operand's MSB=1.
  - On entry to ON, latch the quotient sign (signed & a[31]^b[31]) and the remainder sign (signed & a[31]), and clear cnt to 0.
- ON, each cycle: partial remainder R (DATA_W+1 bits) ← {R, next dividend bit}.
  - If R ≥ |b|: R ← R−|b|, shift quotient bit 1.
  - Otherwise shift quotient bit 0.
  - cnt increments.
  - After the 32nd iteration (cnt=DATA_W), the next edge applies sign correction (negate the quotient and/or remainder per the latched signs), registers result_o, sets ready_o=1, and moves to END.
- BYZERO: the next edge → END with result_o=0 and ready_o=1. Divide-by-zero is architecturally undefined; this block fixes the result at 0.
- END
  - Holds result_o and ready_o while start_i=1.
  - When start_i=0, the next edge → FREE with ready_o=0 and result_o=0.
- annul_i=1 in ON or BYZERO: the next edge → FREE, ready_o stays 0, and no result is produced.
- annul_i has priority over start_i in FREE.
- Arithmetic
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
  - The magnitude 2^31 is handled in DATA_W-bit unsigned form without loss.
- Reset (rst=0, at any time, including mid-operation) → FREE, cnt=0, ready_o=0, result_o=0, all operand and sign latches 0.

## Timing
- Edge T0 samples start_i=1 in FREE.
- ON performs its 32 iterations on edges T1..T32.
- Edge T33 enters END; ready_o=1 from T33 onward.
- Latency is 33 cycles from the start-sampling edge to ready_o.
- Divide-by-zero: T0 → BYZERO, T1 → END, so ready_o=1 after edge T1.
- EX stall term = start_i & ~ready_o. EX drops start_i in the cycle it captures result_o.
- Back-to-back operations need at least one cycle with start_i=0 between them. FREE is re-entered one edge after start_i falls.
- Changes to operand inputs while in ON or END are ignored.
- All outputs are registered; there is no combinational path from any input to ready_o or result_o.

## Test plan
- Unsigned 100 / 7:
  - assert start at T0 and hold it.
  - Require ready_o low on edges T1..T32 and rising at T33.
  - Require result_o=0x00000002_0000000E.
  - Drop start and require ready_o=0 and result_o=0 one edge later.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002) → result_o=0xFFFFFFFF_FFFFFFFD. Signed 7 / −2 → 0x00000001_FFFFFFFD.
- Divide-by-zero: 5 / 0, in both signed and unsigned mode → ready_o=1 after edge T1, result_o=0.
- Edge values:
  - Signed 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000.
  - Unsigned 0xFFFFFFFF / 1 → 0x00000000_FFFFFFFF.
  - Unsigned 3 / 0xFFFFFFFF → 0x00000003_00000000.
- annul_i pulsed at T10 during ON:
  - FREE follows on the next edge and ready_o never rises.
  - A fresh unsigned 9 / 3 start then completes in 33 cycles with result 0x00000000_00000003.
- rst pulled low asynchronously at T20 of an operation → all outputs read 0 immediately, the FSM is in FREE, and a new operation after release behaves normally.

Source files
------------

// File: rtl/div_unit_if.sv
// Handshake/operand bundle between the EX stage (master) and the divider (slave).
interface div_unit_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS div/divu.
// Operands are reduced to magnitudes on start, one quotient bit is produced
// per cycle, and signs are reapplied when the result is registered.
// result_o = {remainder, quotient}, valid while ready_o=1.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

    state_e              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W:0]     rem;       // partial remainder, one guard bit
    logic [DATA_W-1:0]   dq;        // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0]   divisor;   // |b|
    logic                q_neg;
    logic                r_neg;
    logic [2*DATA_W-1:0] result_q;
    logic                ready_q;

    logic                go;
    logic                a_neg, b_neg;
    logic [DATA_W-1:0]   a_abs, b_abs;
    logic [DATA_W:0]     rem_sh;
    logic [DATA_W:0]     rem_nxt;
    logic                q_bit;
    logic                last_iter;
    logic [DATA_W-1:0]   q_fin, r_fin;

    assign go        = bus.start_i & ~bus.annul_i;
    assign a_neg     = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    assign b_neg     = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    // 2^31 magnitude stays exact: -0x80000000 == 0x80000000 as unsigned.
    assign a_abs     = a_neg ? -bus.opdata1_i : bus.opdata1_i;
    assign b_abs     = b_neg ? -bus.opdata2_i : bus.opdata2_i;

    assign rem_sh    = {rem[DATA_W-1:0], dq[DATA_W-1]};
    assign q_bit     = (rem_sh >= {1'b0, divisor});
    assign rem_nxt   = q_bit ? (rem_sh - {1'b0, divisor}) : rem_sh;
    assign last_iter = (cnt == CNT_W'(DATA_W));

    assign q_fin     = q_neg ? -dq : dq;
    assign r_fin     = r_neg ? -rem[DATA_W-1:0] : rem[DATA_W-1:0];

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FREE;
        else      state <= state_nxt;
    end

    // Next-state logic; annul wins over start and over any in-flight work.
    always_comb begin
        state_nxt = state;
        case (state)
            FREE: begin
                if (go) state_nxt = (bus.opdata2_i == '0) ? BYZERO : ON;
            end
            BYZERO: begin
                state_nxt = bus.annul_i ? FREE : END;
            end
            ON: begin
                if (bus.annul_i)    state_nxt = FREE;
                else if (last_iter) state_nxt = END;
            end
            END: begin
                if (!bus.start_i) state_nxt = FREE;
            end
            default: state_nxt = FREE;
        endcase
    end

    // Datapath: operand latch, per-cycle iteration, result/ready registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            rem      <= '0;
            dq       <= '0;
            divisor  <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    ready_q  <= 1'b0;
                    result_q <= '0;
                    if (go && bus.opdata2_i != '0) begin
                        dq      <= a_abs;
                        divisor <= b_abs;
                        rem     <= '0;
                        cnt     <= '0;
                        q_neg   <= a_neg ^ b_neg;
                        r_neg   <= a_neg;
                    end
                end
                BYZERO: begin
                    if (!bus.annul_i) begin
                        result_q <= '0;
                        ready_q  <= 1'b1;
                    end
                end
                ON: begin
                    if (!bus.annul_i) begin
                        if (last_iter) begin
                            result_q <= {r_fin, q_fin};
                            ready_q  <= 1'b1;
                        end else begin
                            rem <= rem_nxt;
                            dq  <= {dq[DATA_W-2:0], q_bit};
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                END: begin
                    if (!bus.start_i) begin
                        ready_q  <= 1'b0;
                        result_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
